// File: rtl/pong_sound_pkg.sv
// Source/state encodings, default tone and duration constants, and priority helpers
// shared by the buzzer arbitration logic.
package pong_sound_pkg;

  typedef enum logic [1:0] {
    SRC_WALL  = 2'd0,
    SRC_PAD   = 2'd1,
    SRC_POWER = 2'd2,
    SRC_SCORE = 2'd3
  } src_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [15:0] DEF_WALL_DIV    = 16'd12000;
  localparam logic [15:0] DEF_PAD_DIV     = 16'd8000;
  localparam logic [15:0] DEF_POWER_DIV   = 16'd5000;
  localparam logic [15:0] DEF_SCORE_DIV_A = 16'd10000;
  localparam logic [15:0] DEF_SCORE_DIV_B = 16'd15000;
  localparam logic [7:0]  DEF_WALL_LEN    = 8'd4;
  localparam logic [7:0]  DEF_PAD_LEN     = 8'd6;
  localparam logic [7:0]  DEF_POWER_LEN   = 8'd10;
  localparam logic [7:0]  DEF_SCORE_LEN   = 8'd30;
  localparam logic [7:0]  DEF_SCORE_STEP  = 8'd5;
  localparam logic [7:0]  DEF_GAP_TICKS   = 8'd1;

  // Highest-priority source present in a {score,power,pad,wall} vector.
  function automatic src_t top_src(input logic [3:0] p);
    src_t s;
    s = SRC_WALL;
    if (p[3])      s = SRC_SCORE;
    else if (p[2]) s = SRC_POWER;
    else if (p[1]) s = SRC_PAD;
    return s;
  endfunction

  function automatic logic [3:0] src_bit(input src_t s);
    return 4'b0001 << s;
  endfunction

endpackage

// File: rtl/buzzer_arbiter_if.sv
// Request, tick and status bundle between the game logic and the buzzer arbiter.
interface buzzer_arbiter_if;
  import pong_sound_pkg::*;

  logic       tick_en;
  logic       req_wall;
  logic       req_pad;
  logic       req_power;
  logic       req_score;
  logic       mute;
  logic       buzzer;
  logic       busy;
  src_t       active_src;
  logic [3:0] pending;

  modport master (
    output tick_en, req_wall, req_pad, req_power, req_score, mute,
    input  buzzer, busy, active_src, pending
  );

  modport slave (
    input  tick_en, req_wall, req_pad, req_power, req_score, mute,
    output buzzer, busy, active_src, pending
  );

endinterface

// File: rtl/tone_gen.sv
// Half-period divider: toggles tone every div enabled cycles; clr restarts the
// count with tone low on the next edge.
module tone_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [15:0] div,
  output logic        tone
);

  logic [15:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt  <= '0;
      tone <= 1'b0;
    end else if (en) begin
      if (cnt >= div - 16'd1) begin
        cnt  <= '0;
        tone <= ~tone;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/buzzer_arbiter.sv
// Fixed-priority buzzer arbiter: latches sound requests, plays the highest one with
// tick-timed length and per-source tone, preempting only for strictly higher sources.
module buzzer_arbiter
  import pong_sound_pkg::*;
#(
  parameter logic [15:0] WALL_DIV    = DEF_WALL_DIV,
  parameter logic [15:0] PAD_DIV     = DEF_PAD_DIV,
  parameter logic [15:0] POWER_DIV   = DEF_POWER_DIV,
  parameter logic [15:0] SCORE_DIV_A = DEF_SCORE_DIV_A,
  parameter logic [15:0] SCORE_DIV_B = DEF_SCORE_DIV_B,
  parameter logic [7:0]  WALL_LEN    = DEF_WALL_LEN,
  parameter logic [7:0]  PAD_LEN     = DEF_PAD_LEN,
  parameter logic [7:0]  POWER_LEN   = DEF_POWER_LEN,
  parameter logic [7:0]  SCORE_LEN   = DEF_SCORE_LEN,
  parameter logic [7:0]  SCORE_STEP  = DEF_SCORE_STEP,
  parameter logic [7:0]  GAP_TICKS   = DEF_GAP_TICKS
) (
  input  logic            clk,
  input  logic            rst,
  buzzer_arbiter_if.slave bus
);

  state_t      state;
  src_t        active_src;
  logic [3:0]  pend;
  logic [7:0]  len_cnt;
  logic [7:0]  step_cnt;
  logic [7:0]  gap_cnt;
  logic        trill_b;

  logic [3:0]  req_vec;
  logic [3:0]  set_vec;
  logic [3:0]  clr_vec;
  logic [3:0]  above_mask;
  logic        start;
  src_t        start_src;
  logic        retrig;
  logic        play_end;
  logic        trill_tick;
  logic        trill_sw;
  logic        tone;
  logic        tone_clr;
  logic        tone_en;
  logic [15:0] div_sel;

  function automatic logic [7:0] len_of(input src_t s);
    logic [7:0] l;
    l = WALL_LEN;
    case (s)
      SRC_WALL:  l = WALL_LEN;
      SRC_PAD:   l = PAD_LEN;
      SRC_POWER: l = POWER_LEN;
      SRC_SCORE: l = SCORE_LEN;
      default:   l = WALL_LEN;
    endcase
    return l;
  endfunction

  always_comb begin
    req_vec    = {bus.req_score, bus.req_power, bus.req_pad, bus.req_wall};
    retrig     = (state == PLAY) && req_vec[active_src];
    // A repeat of the playing sound extends it rather than queueing a second copy.
    set_vec    = req_vec;
    if (state == PLAY) set_vec[active_src] = 1'b0;
    above_mask = 4'b1110 << active_src;
    start_src  = top_src(pend);
    start      = (state == IDLE) ? (pend != 4'd0) : ((pend & above_mask) != 4'd0);
    clr_vec    = start ? src_bit(start_src) : 4'd0;
    play_end   = (state == PLAY) && bus.tick_en && (len_cnt == 8'd1) && !retrig;
    trill_tick = (state == PLAY) && (active_src == SRC_SCORE) && bus.tick_en && !play_end;
    trill_sw   = trill_tick && (step_cnt == 8'd1);
    tone_en    = (state == PLAY);
    tone_clr   = start || trill_sw || (state != PLAY);
  end

  always_comb begin
    div_sel = WALL_DIV;
    case (active_src)
      SRC_WALL:  div_sel = WALL_DIV;
      SRC_PAD:   div_sel = PAD_DIV;
      SRC_POWER: div_sel = POWER_DIV;
      SRC_SCORE: div_sel = trill_b ? SCORE_DIV_B : SCORE_DIV_A;
      default:   div_sel = WALL_DIV;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      active_src <= SRC_WALL;
      pend       <= '0;
      len_cnt    <= '0;
      step_cnt   <= '0;
      gap_cnt    <= '0;
      trill_b    <= 1'b0;
    end else begin
      pend <= (pend & ~clr_vec) | set_vec;
      if (start) begin
        state      <= PLAY;
        active_src <= start_src;
        len_cnt    <= len_of(start_src);
        step_cnt   <= SCORE_STEP;
        gap_cnt    <= '0;
        trill_b    <= 1'b0;
      end else begin
        case (state)
          PLAY: begin
            if (retrig) begin
              len_cnt <= len_of(active_src);
            end else if (play_end) begin
              if (GAP_TICKS == 8'd0) begin
                state <= IDLE;
              end else begin
                state   <= GAP;
                gap_cnt <= GAP_TICKS;
              end
            end else if (bus.tick_en) begin
              len_cnt <= len_cnt - 8'd1;
            end
            if (trill_tick) begin
              if (step_cnt == 8'd1) begin
                step_cnt <= SCORE_STEP;
                trill_b  <= ~trill_b;
              end else begin
                step_cnt <= step_cnt - 8'd1;
              end
            end
          end
          GAP: begin
            if (bus.tick_en) begin
              if (gap_cnt == 8'd1) state <= IDLE;
              else                 gap_cnt <= gap_cnt - 8'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  tone_gen u_tone (
    .clk  (clk),
    .rst  (rst),
    .clr  (tone_clr),
    .en   (tone_en),
    .div  (div_sel),
    .tone (tone)
  );

  assign bus.buzzer     = tone & ~bus.mute & (state == PLAY);
  assign bus.busy       = (state != IDLE);
  assign bus.active_src = active_src;
  assign bus.pending    = pend;

endmodule

// File: tb/tb_buzzer_arbiter.sv
// Scoreboard bench: stimulus queues expected sound segments and status probes;
// a negedge monitor measures each busy segment and checks it against the queue.
module tb_buzzer_arbiter;

  typedef struct packed {
    int src;
    int ticks;
    int first;
    int maxw;
  } seg_t;

  typedef struct packed {
    logic [3:0] pend;
    logic       busy;
    logic       buz_chk;
  } probe_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  seg_t   exp_q[$];
  probe_t probe_q[$];

  seg_t   cur;
  bit     in_seg = 1'b0;
  int     hi_run = 0;
  int     seg_no = 0;
  int     probe_no = 0;

  always #5 clk = ~clk;

  buzzer_arbiter_if ifc ();

  buzzer_arbiter #(
    .WALL_DIV    (16'd4),
    .PAD_DIV     (16'd3),
    .POWER_DIV   (16'd2),
    .SCORE_DIV_A (16'd5),
    .SCORE_DIV_B (16'd7),
    .WALL_LEN    (8'd2),
    .PAD_LEN     (8'd3),
    .POWER_LEN   (8'd4),
    .SCORE_LEN   (8'd6),
    .SCORE_STEP  (8'd2),
    .GAP_TICKS   (8'd1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  // Frame tick: one cycle high every 100 clocks.
  initial begin
    ifc.tick_en = 1'b0;
    forever begin
      repeat (99) @(posedge clk);
      #1 ifc.tick_en = 1'b1;
      @(posedge clk);
      #1 ifc.tick_en = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns off cycles (+1ns) after the n-th upcoming tick edge.
  task automatic at_tick(input int n, input int off);
    for (int i = 0; i < n; i++) begin
      do @(posedge clk); while (!ifc.tick_en);
    end
    repeat (off) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] r);
    {ifc.req_score, ifc.req_power, ifc.req_pad, ifc.req_wall} = r;
    @(posedge clk);
    #1;
    {ifc.req_score, ifc.req_power, ifc.req_pad, ifc.req_wall} = 4'b0000;
  endtask

  task automatic probe(input logic [3:0] pend, input logic busy, input logic buz_chk);
    probe_t p;
    p.pend    = pend;
    p.busy    = busy;
    p.buz_chk = buz_chk;
    probe_q.push_back(p);
  endtask

  task automatic expect_seg(input int src, input int ticks, input int first, input int maxw);
    seg_t s;
    s.src   = src;
    s.ticks = ticks;
    s.first = first;
    s.maxw  = maxw;
    exp_q.push_back(s);
  endtask

  // Monitor: probes, then busy-segment measurement (source, ticks, high-pulse widths).
  initial begin
    probe_t p;
    seg_t   e;
    forever begin
      @(negedge clk);
      if (probe_q.size() > 0) begin
        p = probe_q.pop_front();
        checks++;
        if (ifc.pending !== p.pend || ifc.busy !== p.busy ||
            (p.buz_chk && ifc.buzzer !== 1'b0)) begin
          errors++;
          $display("FAIL probe%0d pending/busy/buzzer got %b/%b/%b want %b/%b/%s",
                   probe_no, ifc.pending, ifc.busy, ifc.buzzer, p.pend, p.busy,
                   p.buz_chk ? "0" : "x");
        end
        probe_no++;
      end
      if (in_seg && (!ifc.busy || int'(ifc.active_src) != cur.src)) begin
        in_seg = 1'b0;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL seg%0d unexpected sound src=%0d ticks=%0d first=%0d max=%0d",
                   seg_no, cur.src, cur.ticks, cur.first, cur.maxw);
        end else begin
          e = exp_q.pop_front();
          if (cur != e) begin
            errors++;
            $display("FAIL seg%0d src/ticks/first/max got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                     seg_no, cur.src, cur.ticks, cur.first, cur.maxw,
                     e.src, e.ticks, e.first, e.maxw);
          end
        end
        seg_no++;
      end
      if (!in_seg && ifc.busy) begin
        in_seg    = 1'b1;
        cur.src   = int'(ifc.active_src);
        cur.ticks = 0;
        cur.first = 0;
        cur.maxw  = 0;
        hi_run    = 0;
      end
      if (in_seg) begin
        if (ifc.tick_en) cur.ticks = cur.ticks + 1;
        if (ifc.buzzer) begin
          hi_run++;
        end else if (hi_run != 0) begin
          if (cur.first == 0) cur.first = hi_run;
          if (hi_run > cur.maxw) cur.maxw = hi_run;
          hi_run = 0;
        end
      end
    end
  end

  initial begin
    ifc.req_wall  = 1'b0;
    ifc.req_pad   = 1'b0;
    ifc.req_power = 1'b0;
    ifc.req_score = 1'b0;
    ifc.mute      = 1'b0;

    // Reset state
    step(3);
    probe(4'b0000, 1'b0, 1'b1);
    rst = 1'b0;
    step(2);
    probe(4'b0000, 1'b0, 1'b1);

    // Reset in the middle of a score sound with a wall request pending
    at_tick(1, 10);
    expect_seg(3, 0, 5, 5);
    pulse(4'b1000);
    step(40);
    pulse(4'b0001);
    probe(4'b0001, 1'b1, 1'b0);
    rst = 1'b1;
    step(1);
    probe(4'b0000, 1'b0, 1'b1);
    step(10);
    probe(4'b0000, 1'b0, 1'b1);
    rst = 1'b0;

    // Single wall: 2 ticks of period-8 tone, 1 silent tick
    at_tick(1, 10);
    expect_seg(0, 3, 4, 4);
    pulse(4'b0001);
    probe(4'b0001, 1'b0, 1'b1);
    step(1);
    probe(4'b0000, 1'b1, 1'b1);
    at_tick(3, 5);

    // Pad preempted by score; score trills 10/14 clk; pad not replayed
    at_tick(1, 10);
    expect_seg(1, 1, 3, 3);
    pulse(4'b0010);
    at_tick(1, 10);
    expect_seg(3, 7, 5, 7);
    pulse(4'b1000);
    probe(4'b1000, 1'b1, 1'b0);
    step(1);
    probe(4'b0000, 1'b1, 1'b1);
    at_tick(7, 5);

    // Wall queued behind power, starts right after the gap
    at_tick(1, 10);
    expect_seg(2, 5, 2, 2);
    pulse(4'b0100);
    at_tick(1, 10);
    expect_seg(0, 3, 4, 4);
    pulse(4'b0001);
    probe(4'b0001, 1'b1, 1'b0);
    step(50);
    probe(4'b0001, 1'b1, 1'b0);
    at_tick(4, 0);
    probe(4'b0001, 1'b0, 1'b1);
    step(1);
    probe(4'b0000, 1'b1, 1'b1);
    at_tick(3, 5);

    // Simultaneous wall/pad/power: served power, pad, wall
    at_tick(1, 10);
    expect_seg(2, 5, 2, 2);
    expect_seg(1, 4, 3, 3);
    expect_seg(0, 3, 4, 4);
    pulse(4'b0111);
    probe(4'b0111, 1'b0, 1'b1);
    step(1);
    probe(4'b0011, 1'b1, 1'b1);
    at_tick(12, 5);

    // Pad retriggered after its second tick: 3 more ticks, nothing pended
    at_tick(1, 10);
    expect_seg(1, 6, 3, 3);
    pulse(4'b0010);
    at_tick(2, 10);
    pulse(4'b0010);
    probe(4'b0000, 1'b1, 1'b0);
    at_tick(4, 5);

    // Muted wall: silent, timing unchanged
    at_tick(1, 10);
    ifc.mute = 1'b1;
    expect_seg(0, 3, 0, 0);
    pulse(4'b0001);
    step(30);
    probe(4'b0000, 1'b1, 1'b1);
    at_tick(3, 5);
    ifc.mute = 1'b0;

    step(10);
    checks++;
    if (exp_q.size() != 0 || probe_q.size() != 0 || in_seg) begin
      errors++;
      $display("FAIL drain: leftover expected=%0d probes=%0d open_seg=%0d want 0/0/0",
               exp_q.size(), probe_q.size(), in_seg);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/buzzer_arbiter.md
Name: buzzer_arbiter

Overview:
- Shares the single piezo buzzer pin among sound-event requesters: wall bounce, paddle hit, point scored, powerup caught.
- Fixed priority, preemption by strictly higher priority, one-deep pending latch per source, frame-tick-timed durations, per-source tone generation; the score sound is a two-tone trill.
- Sits between the collision/score/powerup logic and the buzzer output pin, fed by the enable generator's frame tick.

Parameters:
- WALL_DIV, 16'd12000, half-period in clk cycles of wall tone
- PAD_DIV, 16'd8000, half-period of paddle tone
- POWER_DIV, 16'd5000, half-period of powerup tone
- SCORE_DIV_A, 16'd10000, score trill tone A half-period
- SCORE_DIV_B, 16'd15000, score trill tone B half-period
- WALL_LEN, 8'd4, wall sound length in ticks
- PAD_LEN, 8'd6, paddle sound length in ticks
- POWER_LEN, 8'd10, powerup sound length in ticks
- SCORE_LEN, 8'd30, score sound length in ticks
- SCORE_STEP, 8'd5, ticks per trill tone before alternating
- GAP_TICKS, 8'd1, silent ticks between consecutive sounds

Ports:
- clk  in  1  system clock (PLL global clock)
- rst  in  1  synchronous reset, active-high
- tick_en  in  1  one-cycle frame tick pulse
- req_wall  in  1  wall collision request pulse
- req_pad  in  1  paddle collision request pulse
- req_power  in  1  powerup caught request pulse
- req_score  in  1  point scored request pulse (lossA|lossB rising)
- mute  in  1  forces buzzer low; timing continues
- buzzer  out  1  square-wave drive to pin
- busy  out  1  high in PLAY or GAP
- active_src  out  2  0 wall, 1 pad, 2 power, 3 score; valid while busy
- pending  out  4  {score,power,pad,wall} latched requests

Behaviour:
- Single clock domain; reset synchronous, active-high. On rst: state IDLE; buzzer 0, busy 0, active_src 0, pending 0; all counters 0. Reset mid-sound: buzzer 0 on the cycle after rst is sampled.
- Priority: score(3) > power(2) > pad(1) > wall(0).
- Request capture: a req high in a cycle sets its pending bit at that clock edge. Exception: a req equal to active_src in PLAY retriggers instead (length counter reloaded, tone phase kept, pending not set).
- States: IDLE, PLAY, GAP.
- IDLE: if pending != 0, next edge -> PLAY with the highest pending source: its pending bit cleared, len_cnt loaded with its LEN, tone counter 0, buzzer 0, score trill at tone A with step_cnt = SCORE_STEP. Pending bit and req set in the same cycle start on the next edge.
- PLAY:
  - Tone counter increments each clk; at DIV-1 it resets to 0 and the internal tone toggles.
  - buzzer = tone & ~mute.
  - On tick_en, len_cnt decrements. When len_cnt == 1 and tick_en -> GAP with gap_cnt = GAP_TICKS.
  - Score: on tick_en step_cnt decrements; at 1 it reloads and toggles A/B. The tone counter resets at the switch.
- GAP: buzzer 0; on tick_en gap_cnt decrements; at 1 -> IDLE. If GAP_TICKS == 0, PLAY goes directly to IDLE.
- Preemption: in PLAY or GAP, any pending bit strictly above active_src causes the next edge to enter PLAY with that source, loaded as from IDLE. The preempted sound is discarded, not re-pended. Lower or equal pending bits wait.
- Simultaneous requests in one cycle: all latch; the highest is served first.
- tick_en and a state-ending condition in the same cycle: transition as specified; no double decrement.
- Widths: tone counters 16-bit, length/step/gap counters 8-bit, no wrap. LEN parameters are ≥ 1.

Decomposition:
- Shared package pong_sound_pkg: source encodings SRC_WALL/SRC_PAD/SRC_POWER/SRC_SCORE, state encoding (IDLE/PLAY/GAP), default DIV/LEN constants.
- Sub-module tone_gen (16-bit half-period divider with sync clear, enable, toggle output), instantiated once and retargeted via a div mux.

Test Plan (bench params: WALL_DIV=4, PAD_DIV=3, POWER_DIV=2, SCORE_DIV_A=5, SCORE_DIV_B=7, LENs 2/3/4/6, SCORE_STEP=2, GAP_TICKS=1, tick_en every 100 clk):
- Reset: rst during score PLAY -> next cycle buzzer=0, busy=0, pending=4'b0000. Hold 10 cycles -> unchanged.
- Single wall: req_wall pulse -> pending=0001 one cycle. Then busy=1, active_src=0, buzzer period 8 clk for 2 ticks, silent 1 tick, busy=0.
- Preempt: pad playing, req_score -> next edge active_src=3, trill periods 10 then 14 clk alternating every 2 ticks. Pad not replayed afterward.
- Queue: power playing, req_wall -> pending=0001 held; wall starts immediately after GAP ends.
- Simultaneous: req_wall, req_pad, req_power same cycle -> order power, pad, wall, each separated by a 1-tick gap.
- Retrigger/mute: req_pad at tick 2 of pad -> sound extends 3 more ticks. mute=1 -> buzzer=0 while busy stays 1 and timing is unchanged.
